// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types and constants for the RISC-V front end.
//                XLEN, the canonical NOP encoding (addi x0,x0,0) and the
//                {pc, inst} packet carried from fetch to decode.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- presented to decode whenever IF/ID holds no instruction
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO used by the fetch stage, both as the
//                response buffer (fetch_pkt_t) and as the in-flight address
//                tag queue (PC only, via the element type parameter).
//  Ports       : clk, rst_n (async, active-low), clear (sync flush),
//                push/push_data, pop, head (oldest entry), count (occupancy)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH = 2,            // power of 2, >= 2
  parameter type T     = fetch_pkt_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  // Popping an empty FIFO is a harmless no-op
  assign do_pop = pop & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count says they are live
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count_q != FULL_CNT));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage plus IF/ID register. Owns the PC,
//                issues requests over req/gnt/rvalid, buffers in-order
//                responses and presents {pc, inst} to decode. Supports decode
//                stall and branch redirect (flush).
//  Ports       : clk, reset (async, active-low)
//                stall, flush, redirect_pc      -- from decode / branch unit
//                imem_req/addr/gnt/rvalid/rdata -- instruction memory
//                if_id_valid/pc/inst            -- to decode
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_inst
);

  localparam int              CW           = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0]   CNT_ONE      = CW'(1);
  localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(BUF_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0] if_id_inst_q, if_id_inst_d;

  logic [CW-1:0]   resp_count, tag_count;
  fetch_pkt_t      resp_head, resp_push_data;
  logic [XLEN-1:0] tag_head;
  logic [CW:0]     in_use;
  logic            grant, keep_rsp, drop_rsp, resp_push, resp_pop, if_id_load;

  // Credits cover both in-flight requests and buffered responses, so the
  // response FIFO can never overflow.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, resp_count};
  // Gated by reset so no request is presented while reset is held.
  assign imem_req  = reset & (in_use < CREDIT_LIMIT) & ~flush;
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;

  // Responses for requests issued before a flush are counted off and discarded
  assign keep_rsp  = imem_rvalid & (drop_cnt_q == '0);
  assign drop_rsp  = imem_rvalid & (drop_cnt_q != '0);
  assign resp_push = keep_rsp & ~flush;
  assign resp_push_data = {tag_head, imem_rdata};

  assign if_id_load = ~stall | ~if_id_valid_q;
  assign resp_pop   = ~flush & if_id_load & (resp_count != '0);

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;

    case ({grant, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase

    if (flush) begin
      pc_d          = redirect_pc & ALIGN_MASK;
      // Everything still in flight after this cycle belongs to the old path
      drop_cnt_d    = outstanding_d;
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
    end else begin
      if (grant)    pc_d       = pc_q + PC_STEP;
      if (drop_rsp) drop_cnt_d = drop_cnt_q - CNT_ONE;
      if (if_id_load) begin
        if (resp_count != '0) begin
          if_id_valid_d = 1'b1;
          if_id_pc_d    = resp_head.pc;
          if_id_inst_d  = resp_head.inst;
        end else begin
          if_id_valid_d = 1'b0;
          if_id_inst_d  = NOP_INST;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .T     (fetch_pkt_t)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (flush),
    .push      (resp_push),
    .push_data (resp_push_data),
    .pop       (resp_pop),
    .head      (resp_head),
    .count     (resp_count)
  );

  // The tag queue is cleared on flush, so responses being dropped have no
  // tag left in it; only kept responses pop, otherwise a late drop would
  // steal the tag of a request on the new path.
  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .T     (logic [XLEN-1:0])
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (flush),
    .push      (grant),
    .push_data (pc_q),
    .pop       (keep_rsp),
    .head      (tag_head),
    .count     (tag_count)
  );

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_inst  = if_id_inst_q;

  a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> (outstanding_q != '0));
  a_req_aligned : assert property (@(posedge clk) disable iff (!reset)
    imem_req |-> (imem_addr[1:0] == 2'b00));
  a_tag_available : assert property (@(posedge clk) disable iff (!reset)
    keep_rsp |-> (tag_count != '0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed bench for fetch_unit. Two instances: A (reset PC 0)
//                exercises reset, streaming, stall and flush; B (reset PC
//                0xFFFFFFF8) streams freely to show PC wrap. An in-order
//                memory model answers each grant after LAT cycles with
//                rdata = addr ^ 0xA5A5A5A5.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush;
  logic [31:0] redirect_pc;
  logic        a_req, a_gnt, a_rvalid, a_valid;
  logic [31:0] a_addr, a_rdata, a_pc, a_inst;
  logic        b_req, b_gnt, b_rvalid, b_valid;
  logic [31:0] b_addr, b_rdata, b_pc, b_inst;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(a_gnt), .imem_rvalid(a_rvalid),
    .imem_rdata(a_rdata), .if_id_valid(a_valid), .if_id_pc(a_pc), .if_id_inst(a_inst));

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut_b (
    .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0), .redirect_pc(32'h0),
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(b_gnt), .imem_rvalid(b_rvalid),
    .imem_rdata(b_rdata), .if_id_valid(b_valid), .if_id_pc(b_pc), .if_id_inst(b_inst));

  logic [31:0] a_q[$];
  int          a_due[$];
  logic [31:0] b_q[$];
  int          b_due[$];
  int          cyc, lat;
  int          n_checks, n_errors;

  // Snapshot of DUT A taken mid-cycle, before the closing edge
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst, s_cnt;

  // In-order tracker for A and B
  logic [31:0] exp_pc, exp_b, hold_exp;
  logic        prev_load, track_en;
  int          seen, b_seen, s0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive memory side at the negedge, sample, then let the
  // posedge happen and return #1 after it.
  task automatic cycle();
    @(negedge clk);
    a_rvalid = 1'b0; a_rdata = '0;
    b_rvalid = 1'b0; b_rdata = '0;
    if (!reset) begin
      a_q.delete(); a_due.delete(); b_q.delete(); b_due.delete();
    end else begin
      if (a_q.size() > 0 && a_due[0] <= cyc) begin
        a_rvalid = 1'b1; a_rdata = a_q[0] ^ KEY;
        void'(a_q.pop_front()); void'(a_due.pop_front());
      end
      if (b_q.size() > 0 && b_due[0] <= cyc) begin
        b_rvalid = 1'b1; b_rdata = b_q[0] ^ KEY;
        void'(b_q.pop_front()); void'(b_due.pop_front());
      end
    end
    a_gnt = 1'b1;
    b_gnt = 1'b1;
    #1;
    s_req = a_req; s_addr = a_addr; s_valid = a_valid; s_pc = a_pc; s_inst = a_inst;
    s_cnt = 32'(u_dut_a.resp_count);
    if (track_en && prev_load && a_valid) begin
      check("seq_pc", a_pc, exp_pc);
      check("seq_inst", a_inst, exp_pc ^ KEY);
      exp_pc += 32'd4;
      seen++;
    end
    prev_load = (!stall || !a_valid) && !flush;
    if (reset && b_valid && b_seen < 6) begin
      check("wrap_pc", b_pc, exp_b);
      check("wrap_inst", b_inst, exp_b ^ KEY);
      exp_b += 32'd4;
      b_seen++;
    end
    if (reset && a_req && a_gnt) begin a_q.push_back(a_addr); a_due.push_back(cyc + lat); end
    if (reset && b_req && b_gnt) begin b_q.push_back(b_addr); b_due.push_back(cyc + 1); end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; lat = 1;
    stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    a_gnt = 1'b0; b_gnt = 1'b0; a_rvalid = 1'b0; b_rvalid = 1'b0; a_rdata = '0; b_rdata = '0;
    track_en = 1'b0; prev_load = 1'b0; exp_pc = '0; seen = 0;
    exp_b = 32'hFFFF_FFF8; b_seen = 0;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset held for three cycles
    repeat (3) begin
      cycle();
      check("rst_valid", 32'(s_valid), 32'd0);
      check("rst_inst", s_inst, NOP_INST);
      check("rst_req", 32'(s_req), 32'd0);
    end

    reset = 1'b1; track_en = 1'b1; prev_load = 1'b1; exp_pc = 32'h0;
    cycle();
    check("first_req", 32'(s_req), 32'd1);
    check("first_addr", s_addr, 32'h0);

    // Streaming with 1-cycle memory latency
    repeat (12) cycle();
    check("stream_progress", 32'(seen >= 6), 32'd1);

    // Stall for 4 cycles with a live instruction in IF/ID
    for (int i = 0; i < 10 && !a_valid; i++) cycle();
    check("pre_stall_valid", 32'(a_valid), 32'd1);
    hold_exp = exp_pc;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_valid", 32'(s_valid), 32'd1);
      check("stall_pc", s_pc, hold_exp);
      if (i >= 2) begin
        check("stall_req", 32'(s_req), 32'd0);
        check("stall_fifo", s_cnt, 32'd2);
      end
    end
    stall = 1'b0;
    s0 = seen;
    repeat (10) cycle();
    check("post_stall_progress", 32'(seen >= s0 + 4), 32'd1);

    // Flush with two requests in flight, 3-cycle latency
    lat = 3;
    for (int i = 0; i < 20 && a_q.size() != 2; i++) cycle();
    check("inflight2", 32'(a_q.size()), 32'd2);
    flush = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    check("flush_req", 32'(s_req), 32'd0);
    flush = 1'b0; redirect_pc = '0;
    exp_pc = 32'h0000_0100; seen = 0;
    cycle();
    check("flush_bubble", 32'(s_valid), 32'd0);
    check("flush_addr", s_addr, 32'h0000_0100);
    for (int i = 0; i < 30 && seen < 3; i++) cycle();
    check("flush_resume", 32'(seen >= 3), 32'd1);

    // Flush + stall + gnt together, misaligned redirect
    lat = 2;
    for (int i = 0; i < 10 && !a_valid; i++) cycle();
    stall = 1'b1; flush = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    check("simul_req", 32'(s_req), 32'd0);
    flush = 1'b0; redirect_pc = '0;
    exp_pc = 32'h0000_0100; seen = 0;
    cycle();
    check("simul_valid", 32'(s_valid), 32'd0);
    check("simul_inst", s_inst, NOP_INST);
    check("simul_addr", s_addr, 32'h0000_0100);
    stall = 1'b0;
    for (int i = 0; i < 30 && seen < 2; i++) cycle();
    check("simul_resume", 32'(seen >= 2), 32'd1);

    check("wrap_seen", 32'(b_seen), 32'd6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
